// File: rtl/tx_commit_ctrl.sv
// Ring-space allocator and rate-limited write-pointer committer for a 1024-word TX ring.
// Latency: grant 1 cycle after request; commit 1 cycle after done; commits spaced >= COMMIT_GAP cycles.
// Backpressure: alloc_req is held off (no grant) while space or outstanding slots are short.
module tx_commit_ctrl #(
    parameter int COMMIT_GAP = 8,
    parameter int DEPTH      = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       alloc_req,
    input  logic [7:0] alloc_qwords,
    output logic       alloc_gnt,
    output logic [9:0] alloc_addr,
    input  logic       done_valid,
    input  logic [9:0] rd_addr,
    output logic [9:0] commited_wr_addr,
    output logic       commit_pulse,
    output logic [9:0] free_words,
    output logic       err_underflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [7:0]    GAP_RELOAD = 8'(COMMIT_GAP - 1);

    localparam logic [0:0] A_IDLE = 1'b0;
    localparam logic [0:0] A_GNT  = 1'b1;
    localparam logic [0:0] C_IDLE = 1'b0;
    localparam logic [0:0] C_HOLD = 1'b1;

    logic [0:0]    a_state;
    logic [0:0]    c_state;
    logic [9:0]    alloc_ptr;
    logic [9:0]    pending_end;
    logic          pending;
    logic [7:0]    gap_cnt;

    logic [9:0]    end_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          fifo_full;
    logic          fifo_empty;
    logic          grant_ok;
    logic          pop;
    logic          commit;
    logic [9:0]    next_ptr;
    logic [9:0]    used_words;

    assign fifo_full  = (count == DEPTH_C);
    assign fifo_empty = (count == '0);
    assign next_ptr   = alloc_ptr + {2'b00, alloc_qwords};
    // Space is measured from alloc_ptr so uncommitted regions are never handed out twice.
    assign used_words = alloc_ptr - rd_addr;
    assign grant_ok   = (a_state == A_IDLE) && alloc_req && (alloc_qwords != 8'd0) &&
                        ({2'b00, alloc_qwords} <= free_words) && !fifo_full;
    assign pop        = done_valid && !fifo_empty;
    assign commit     = (c_state == C_IDLE) && pending;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_state    <= A_IDLE;
            alloc_gnt  <= 1'b0;
            alloc_addr <= 10'd0;
            alloc_ptr  <= 10'd0;
            free_words <= 10'd1023;
        end else begin
            free_words <= 10'd1023 - used_words;
            alloc_gnt  <= 1'b0;
            case (a_state)
                A_IDLE: begin
                    if (grant_ok) begin
                        alloc_gnt  <= 1'b1;
                        alloc_addr <= alloc_ptr;
                        alloc_ptr  <= next_ptr;
                        a_state    <= A_GNT;
                    end
                end
                default: a_state <= A_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (grant_ok) begin
            end_mem[wr_ptr] <= next_ptr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (grant_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({grant_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (done_valid && fifo_empty) begin
                err_underflow <= 1'b1;
            end
        end
    end

    // A pop in the commit cycle re-arms pending, so it lands in the next commit window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending          <= 1'b0;
            pending_end      <= 10'd0;
            c_state          <= C_IDLE;
            gap_cnt          <= 8'd0;
            commited_wr_addr <= 10'd0;
            commit_pulse     <= 1'b0;
        end else begin
            commit_pulse <= 1'b0;
            if (pop) begin
                pending_end <= end_mem[rd_ptr];
                pending     <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
            case (c_state)
                C_IDLE: begin
                    if (pending) begin
                        commited_wr_addr <= pending_end;
                        commit_pulse     <= 1'b1;
                        gap_cnt          <= GAP_RELOAD;
                        c_state          <= C_HOLD;
                    end
                end
                default: begin
                    if (gap_cnt <= 8'd1) begin
                        gap_cnt <= 8'd0;
                        c_state <= C_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_commit_ctrl.sv
// Directed bench for tx_commit_ctrl: allocation, wrap, depth limit, commit spacing, underflow, reset abort.
module tb_tx_commit_ctrl;

    logic       clk;
    logic       reset_n;
    logic       alloc_req;
    logic [7:0] alloc_qwords;
    logic       alloc_gnt;
    logic [9:0] alloc_addr;
    logic       done_valid;
    logic [9:0] rd_addr;
    logic [9:0] commited_wr_addr;
    logic       commit_pulse;
    logic [9:0] free_words;
    logic       err_underflow;

    int checks_total  = 0;
    int checks_passed = 0;
    int pulse_cnt;

    tx_commit_ctrl #(.COMMIT_GAP(8), .DEPTH(4)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .alloc_req        (alloc_req),
        .alloc_qwords     (alloc_qwords),
        .alloc_gnt        (alloc_gnt),
        .alloc_addr       (alloc_addr),
        .done_valid       (done_valid),
        .rd_addr          (rd_addr),
        .commited_wr_addr (commited_wr_addr),
        .commit_pulse     (commit_pulse),
        .free_words       (free_words),
        .err_underflow    (err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        alloc_req    = 1'b0;
        alloc_qwords = 8'd0;
        done_valid   = 1'b0;
        rd_addr      = 10'd0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    // Present a request, expect a grant on the next edge, then let the bubble cycle pass.
    task automatic grant(input string tag, input logic [7:0] qw, input logic [9:0] exp_addr);
        alloc_req    = 1'b1;
        alloc_qwords = qw;
        tick();
        chk({tag, "_gnt"}, alloc_gnt, 1);
        chk({tag, "_addr"}, alloc_addr, exp_addr);
        alloc_req = 1'b0;
        tick();
    endtask

    initial begin
        do_reset();
        chk("rst_gnt", alloc_gnt, 0);
        chk("rst_addr", alloc_addr, 0);
        chk("rst_commit", commited_wr_addr, 0);
        chk("rst_pulse", commit_pulse, 0);
        chk("rst_free", free_words, 1023);
        chk("rst_err", err_underflow, 0);

        // Zero-size request must never be granted.
        alloc_req    = 1'b1;
        alloc_qwords = 8'd0;
        tick();
        tick();
        chk("zero_qw_nogrant", alloc_gnt, 0);

        // Basic grant, free space, and single commit.
        alloc_qwords = 8'd100;
        tick();
        chk("basic_gnt", alloc_gnt, 1);
        chk("basic_addr", alloc_addr, 0);
        alloc_req = 1'b0;
        tick();
        chk("basic_gnt_drop", alloc_gnt, 0);
        chk("basic_free", free_words, 923);
        done_valid = 1'b1;
        tick();
        done_valid = 1'b0;
        chk("basic_pre_pulse", commit_pulse, 0);
        tick();
        chk("basic_commit", commited_wr_addr, 100);
        chk("basic_pulse", commit_pulse, 1);
        tick();
        chk("basic_pulse_1cyc", commit_pulse, 0);

        // Fill to 1000 words, then wrap once the reader advances.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            grant("fill", 8'd250, 10'(250 * i));
        end
        chk("fill_free", free_words, 23);
        done_valid = 1'b1;
        repeat (4) tick();
        done_valid   = 1'b0;
        alloc_req    = 1'b1;
        alloc_qwords = 8'd30;
        tick();
        tick();
        tick();
        chk("nospace_nogrant", alloc_gnt, 0);
        chk("nospace_err", err_underflow, 0);
        rd_addr = 10'd10;
        tick();
        chk("nospace_stale_free", alloc_gnt, 0);
        tick();
        chk("wrap_gnt", alloc_gnt, 1);
        chk("wrap_addr", alloc_addr, 1000);
        alloc_req = 1'b0;
        tick();
        chk("wrap_free", free_words, 3);

        // Outstanding limit of four.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            grant("depth", 8'd10, 10'(10 * i));
        end
        alloc_req    = 1'b1;
        alloc_qwords = 8'd10;
        tick();
        tick();
        tick();
        chk("depth_full_nogrant", alloc_gnt, 0);
        done_valid = 1'b1;
        tick();
        done_valid = 1'b0;
        chk("depth_pop_cycle", alloc_gnt, 0);
        tick();
        chk("depth_gnt", alloc_gnt, 1);
        chk("depth_addr", alloc_addr, 40);
        alloc_req = 1'b0;
        tick();

        // Commit spacing and coalescing of three back-to-back dones.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            grant("gap", 8'd10, 10'(10 * i));
        end
        done_valid = 1'b1;
        tick();
        chk("gap_pulse_e1", commit_pulse, 0);
        tick();
        chk("gap_pulse_e2", commit_pulse, 1);
        chk("gap_commit1", commited_wr_addr, 10);
        tick();
        done_valid = 1'b0;
        chk("gap_pulse_e3", commit_pulse, 0);
        pulse_cnt = 0;
        for (int k = 4; k <= 9; k++) begin
            tick();
            if (commit_pulse) pulse_cnt++;
        end
        chk("gap_no_early_commit", pulse_cnt, 0);
        tick();
        chk("gap_pulse_e10", commit_pulse, 1);
        chk("gap_commit2", commited_wr_addr, 30);
        pulse_cnt = 0;
        repeat (20) begin
            tick();
            if (commit_pulse) pulse_cnt++;
        end
        chk("gap_no_third", pulse_cnt, 0);
        chk("gap_commit_hold", commited_wr_addr, 30);

        // Underflow is sticky and does not move the committed pointer.
        done_valid = 1'b1;
        tick();
        done_valid = 1'b0;
        chk("uflow_set", err_underflow, 1);
        tick();
        tick();
        tick();
        chk("uflow_sticky", err_underflow, 1);
        chk("uflow_commit", commited_wr_addr, 30);

        // Reset during the hold window with a commit pending.
        do_reset();
        grant("abort", 8'd10, 10'd0);
        grant("abort", 8'd10, 10'd10);
        done_valid = 1'b1;
        tick();
        tick();
        done_valid = 1'b0;
        chk("abort_commit1", commited_wr_addr, 10);
        tick();
        reset_n = 1'b0;
        #2;
        chk("abort_async_commit", commited_wr_addr, 0);
        chk("abort_async_free", free_words, 1023);
        chk("abort_async_pulse", commit_pulse, 0);
        chk("abort_async_addr", alloc_addr, 0);
        tick();
        reset_n = 1'b1;
        pulse_cnt = 0;
        repeat (15) begin
            tick();
            if (commit_pulse) pulse_cnt++;
        end
        chk("abort_no_commit", pulse_cnt, 0);
        chk("abort_commit_zero", commited_wr_addr, 0);
        grant("abort_regrant", 8'd5, 10'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
